data_mem_ctrl: RTL and testbench
================================

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 Parameter DEPTH, default 1024, byte count of storage; SHALL be a multiple of 4.
REQ-002 Parameter ADDR_W, default 11, address width in bits; 2**ADDR_W SHALL be >= DEPTH.
REQ-003 Parameter WAIT_STATES, default 1, extra cycles inserted before each access completes (0..15).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 req  input  1  request strobe; sampled only in IDLE.
REQ-007 we  input  1  1 = write, 0 = read.
REQ-008 size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-009 sign_ext  input  1  1 = sign-extend byte/halfword reads, 0 = zero-extend.
REQ-010 addr  input  ADDR_W  byte address.
REQ-011 wdata  input  32  write data, right-aligned for byte/halfword.
REQ-012 ack  output  1  one-cycle completion pulse.
REQ-013 rdata  output  32  read result, valid when ack=1.
REQ-014 err_align  output  1  misaligned or illegal-size request, valid when ack=1.
REQ-015 err_range  output  1  address >= DEPTH, valid when ack=1.
REQ-016 busy  output  1  1 whenever state is not IDLE.

Function
REQ-017 FSM states: IDLE, WAIT, RESP; default IDLE.
REQ-018 IDLE + req=1: latch we, size, sign_ext, addr, wdata; next state WAIT if WAIT_STATES>0 and request legal, else RESP; wait counter loaded with WAIT_STATES-1.
REQ-019 WAIT: counter decrements each cycle; at 0, next state RESP.
REQ-020 RESP: ack=1 for exactly one cycle, write committed on the edge leaving RESP, next state IDLE.
REQ-021 Latency: ack asserted WAIT_STATES+1 cycles after the accepting edge; new request accepted no earlier than the cycle after ack.
REQ-022 req while busy=1 SHALL be ignored, not queued; latched fields SHALL not change.
REQ-023 Alignment: halfword requires addr[0]=0, word requires addr[1:0]=00; size=11 always illegal.
REQ-024 Misaligned/illegal request: bypass WAIT, ack next cycle with err_align=1, no write, rdata=0.
REQ-025 Range: addr >= DEPTH (checked only if aligned): bypass WAIT, ack next cycle with err_range=1, no write, rdata=0.
REQ-026 err_align and err_range SHALL never be 1 together; both 0 on successful access.
REQ-027 Big-endian: word at a = {mem[a], mem[a+1], mem[a+2], mem[a+3]}, mem[a] in bits 31:24.
REQ-028 Byte write: wdata[7:0] -> mem[a]; halfword: wdata[15:8] -> mem[a], wdata[7:0] -> mem[a+1]; word per REQ-027; untouched bytes unchanged.
REQ-029 Byte read: mem[a] in rdata[7:0], upper 24 bits extended per sign_ext; halfword: {mem[a],mem[a+1]} in rdata[15:0], upper 16 extended.
REQ-030 Read data SHALL reflect memory at the RESP cycle; write ack returns rdata=0.
REQ-031 rdata, err_align, err_range SHALL hold their value until the next ack.
REQ-032 Storage contents not initialised and not cleared by reset.

Reset
REQ-033 rst=0 SHALL immediately force state IDLE, ack=0, busy=0, rdata=0, err_align=0, err_range=0, counter 0.
REQ-034 Reset asserted before the RESP-exit edge of a write SHALL abort it: memory unchanged.
REQ-035 After rst deasserts, the first req SHALL be accepted on the next rising edge.

Verification
REQ-036 WAIT_STATES=1: word write 0x11223344 at 0x010, then byte read 0x011 sign_ext=0 -> ack 2 cycles after accept, rdata=0x00000022.
REQ-037 Halfword write 0x80FF at 0x020, halfword read sign_ext=1 -> rdata=0xFFFF80FF; sign_ext=0 -> 0x000080FF; word read 0x020 -> 0x80FFxxxx with bytes 2..3 unchanged.
REQ-038 Word read at 0x013 -> ack next cycle, err_align=1, rdata=0; size=11 at 0x000 -> err_align=1; memory unchanged.
REQ-039 Word write at 0x400 (DEPTH=1024) -> err_range=1, err_align=0, no store; reread 0x3FC unaffected.
REQ-040 req held high through busy -> exactly one ack per accepted request; second request accepted cycle after ack.
REQ-041 WAIT_STATES=3: rst pulsed low during WAIT of word write 0xDEADBEEF at 0x040 -> outputs zero immediately, subsequent read of 0x040 returns prior contents.

Source files
------------

// File: rtl/data_mem_ctrl_if.sv
// Request/response bundle for data_mem_ctrl.
// master issues accesses; slave returns ack, read data and error flags.
interface data_mem_ctrl_if #(
  parameter int ADDR_W = 11
);
  logic              req;
  logic              we;
  logic [1:0]        size;
  logic              sign_ext;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              ack;
  logic [31:0]       rdata;
  logic              err_align;
  logic              err_range;
  logic              busy;

  modport master (
    output req, we, size, sign_ext, addr, wdata,
    input  ack, rdata, err_align, err_range, busy
  );

  modport slave (
    input  req, we, size, sign_ext, addr, wdata,
    output ack, rdata, err_align, err_range, busy
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// Byte-addressed big-endian data memory with wait states,
// alignment/range checking and a one-cycle ack per access.
module data_mem_ctrl #(
  parameter int DEPTH       = 1024,
  parameter int ADDR_W      = 11,
  parameter int WAIT_STATES = 1
) (
  input logic            clk,
  input logic            rst,
  data_mem_ctrl_if.slave bus
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [3:0] WS_LOAD =
    4'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

  // Range is resolved at accept time, so only the in-range index is kept.
  typedef struct packed {
    logic          we;
    logic [1:0]    size;
    logic          sext;
    logic [IW-1:0] addr;
    logic [31:0]   wdata;
    logic          ea;
    logic          er;
  } req_t;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  req_t        r_q, r_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ea_q, ea_d;
  logic        er_q, er_d;

  logic [7:0]  mem [DEPTH];
  logic        in_ea, in_er;
  logic [IW-1:0] a0, a1, a2, a3;
  logic [7:0]  b0, b1, b2, b3;
  logic [31:0] rd_val;
  logic        resp, wr_en;

  always_comb begin
    unique case (bus.size)
      2'b00:   in_ea = 1'b0;
      2'b01:   in_ea = bus.addr[0];
      2'b10:   in_ea = |bus.addr[1:0];
      default: in_ea = 1'b1;
    endcase
    in_er = !in_ea &&
      ({{(32-ADDR_W){1'b0}}, bus.addr} >= DEPTH[31:0]);
  end

  assign a0 = r_q.addr;
  assign a1 = a0 + IW'(1);
  assign a2 = a0 + IW'(2);
  assign a3 = a0 + IW'(3);
  assign b0 = mem[a0];
  assign b1 = mem[a1];
  assign b2 = mem[a2];
  assign b3 = mem[a3];

  always_comb begin
    rd_val = 32'd0;
    if (!r_q.we && !r_q.ea && !r_q.er) begin
      unique case (r_q.size)
        2'b00:   rd_val = {{24{r_q.sext & b0[7]}}, b0};
        2'b01:   rd_val = {{16{r_q.sext & b0[7]}}, b0, b1};
        default: rd_val = {b0, b1, b2, b3};
      endcase
    end
  end

  assign resp  = (state_q == RESP);
  assign wr_en = resp && r_q.we && !r_q.ea && !r_q.er;

  assign bus.ack       = resp;
  assign bus.busy      = (state_q != IDLE);
  assign bus.rdata     = resp ? rd_val : rdata_q;
  assign bus.err_align = resp ? r_q.ea : ea_q;
  assign bus.err_range = resp ? r_q.er : er_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    rdata_d = resp ? rd_val : rdata_q;
    ea_d    = resp ? r_q.ea : ea_q;
    er_d    = resp ? r_q.er : er_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req) begin
          r_d.we    = bus.we;
          r_d.size  = bus.size;
          r_d.sext  = bus.sign_ext;
          r_d.addr  = bus.addr[IW-1:0];
          r_d.wdata = bus.wdata;
          r_d.ea    = in_ea;
          r_d.er    = in_er;
          cnt_d     = WS_LOAD;
          state_d   = (WAIT_STATES > 0 && !in_ea && !in_er)
                      ? WAIT : RESP;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      rdata_q <= '0;
      ea_q    <= 1'b0;
      er_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      rdata_q <= rdata_d;
      ea_q    <= ea_d;
      er_q    <= er_d;
    end
  end

  // Storage is not reset; an async reset drops RESP, so no write.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      unique case (r_q.size)
        2'b00: mem[a0] <= r_q.wdata[7:0];
        2'b01: begin
          mem[a0] <= r_q.wdata[15:8];
          mem[a1] <= r_q.wdata[7:0];
        end
        default: begin
          mem[a0] <= r_q.wdata[31:24];
          mem[a1] <= r_q.wdata[23:16];
          mem[a2] <= r_q.wdata[15:8];
          mem[a3] <= r_q.wdata[7:0];
        end
      endcase
    end
  end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: vector table through a scoreboard,
// plus held-request and reset-abort sequences on two instances.
module tb_data_mem_ctrl;
  localparam int WS0 = 1;
  localparam int WS1 = 3;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sext;
    logic [10:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ea;
    logic        er;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        ea;
    logic        er;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_s    [2];
  logic        req_s    [2];
  logic        we_s     [2];
  logic [1:0]  size_s   [2];
  logic        sext_s   [2];
  logic [10:0] addr_s   [2];
  logic [31:0] wdata_s  [2];
  logic        ack_w    [2];
  logic [31:0] rdata_w  [2];
  logic        ea_w     [2];
  logic        er_w     [2];
  logic        busy_w   [2];

  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];
  vec_t tbl[$];

  always #5 clk = ~clk;

  data_mem_ctrl_if #(.ADDR_W(11)) bus0 ();
  data_mem_ctrl_if #(.ADDR_W(11)) bus1 ();

  assign bus0.req      = req_s[0];
  assign bus0.we       = we_s[0];
  assign bus0.size     = size_s[0];
  assign bus0.sign_ext = sext_s[0];
  assign bus0.addr     = addr_s[0];
  assign bus0.wdata    = wdata_s[0];
  assign ack_w[0]      = bus0.ack;
  assign rdata_w[0]    = bus0.rdata;
  assign ea_w[0]       = bus0.err_align;
  assign er_w[0]       = bus0.err_range;
  assign busy_w[0]     = bus0.busy;

  assign bus1.req      = req_s[1];
  assign bus1.we       = we_s[1];
  assign bus1.size     = size_s[1];
  assign bus1.sign_ext = sext_s[1];
  assign bus1.addr     = addr_s[1];
  assign bus1.wdata    = wdata_s[1];
  assign ack_w[1]      = bus1.ack;
  assign rdata_w[1]    = bus1.rdata;
  assign ea_w[1]       = bus1.err_align;
  assign er_w[1]       = bus1.err_range;
  assign busy_w[1]     = bus1.busy;

  data_mem_ctrl #(
    .DEPTH(1024), .ADDR_W(11), .WAIT_STATES(WS0)
  ) dut0 (
    .clk(clk), .rst(rst_s[0]), .bus(bus0)
  );

  data_mem_ctrl #(
    .DEPTH(1024), .ADDR_W(11), .WAIT_STATES(WS1)
  ) dut1 (
    .clk(clk), .rst(rst_s[1]), .bus(bus1)
  );

  function automatic vec_t mk(
    input logic we, input logic [1:0] size, input logic sext,
    input logic [10:0] addr, input logic [31:0] wdata,
    input logic [31:0] rdata, input logic ea, input logic er
  );
    vec_t v;
    v.we = we; v.size = size; v.sext = sext; v.addr = addr;
    v.wdata = wdata; v.rdata = rdata; v.ea = ea; v.er = er;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, want);
    end
  endtask

  task automatic drive(input int d, input vec_t v);
    we_s[d]    = v.we;
    size_s[d]  = v.size;
    sext_s[d]  = v.sext;
    addr_s[d]  = v.addr;
    wdata_s[d] = v.wdata;
    req_s[d]   = 1'b1;
  endtask

  task automatic issue(input int d, input vec_t v);
    exp_t e;
    int   lat;
    e.rdata = v.rdata;
    e.ea    = v.ea;
    e.er    = v.er;
    e.lat   = (v.ea || v.er) ? 1 : ((d == 0) ? WS0 : WS1) + 1;
    sb.push_back(e);
    @(negedge clk);
    drive(d, v);
    @(posedge clk);
    @(negedge clk);
    req_s[d] = 1'b0;
    chk("busy_after_accept", 32'(busy_w[d]), 32'd1);
    lat = 1;
    while (!ack_w[d] && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    e = sb.pop_front();
    chk("ack_latency", lat, e.lat);
    chk("rdata", rdata_w[d], e.rdata);
    chk("err_align", 32'(ea_w[d]), 32'(e.ea));
    chk("err_range", 32'(er_w[d]), 32'(e.er));
    @(negedge clk);
    chk("rdata_hold", rdata_w[d], e.rdata);
    chk("idle_after_ack", 32'(busy_w[d] | ack_w[d]), 32'd0);
  endtask

  task automatic chk_zero(input int d, input string nm);
    chk({nm, "_ack"},   32'(ack_w[d]),  32'd0);
    chk({nm, "_busy"},  32'(busy_w[d]), 32'd0);
    chk({nm, "_rdata"}, rdata_w[d],     32'd0);
    chk({nm, "_ea"},    32'(ea_w[d]),   32'd0);
    chk({nm, "_er"},    32'(er_w[d]),   32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int d = 0; d < 2; d++) begin
      rst_s[d] = 1'b0; req_s[d] = 1'b0; we_s[d] = 1'b0;
      size_s[d] = 2'b00; sext_s[d] = 1'b0;
      addr_s[d] = '0; wdata_s[d] = '0;
    end

    tbl.push_back(mk(1, 2, 0, 11'h010, 32'h11223344, 32'h0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 11'h011, 32'h0, 32'h00000022, 0, 0));
    tbl.push_back(mk(0, 2, 0, 11'h010, 32'h0, 32'h11223344, 0, 0));
    tbl.push_back(mk(1, 2, 0, 11'h020, 32'h12345678, 32'h0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 11'h020, 32'h000080FF, 32'h0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 11'h020, 32'h0, 32'hFFFF80FF, 0, 0));
    tbl.push_back(mk(0, 1, 0, 11'h020, 32'h0, 32'h000080FF, 0, 0));
    tbl.push_back(mk(0, 2, 0, 11'h020, 32'h0, 32'h80FF5678, 0, 0));
    tbl.push_back(mk(0, 2, 0, 11'h013, 32'h0, 32'h0, 1, 0));
    tbl.push_back(mk(0, 3, 0, 11'h000, 32'h0, 32'h0, 1, 0));
    tbl.push_back(mk(1, 3, 0, 11'h010, 32'hFFFFFFFF, 32'h0, 1, 0));
    tbl.push_back(mk(1, 1, 0, 11'h021, 32'h0000FFFF, 32'h0, 1, 0));
    tbl.push_back(mk(0, 2, 0, 11'h010, 32'h0, 32'h11223344, 0, 0));
    tbl.push_back(mk(0, 2, 0, 11'h020, 32'h0, 32'h80FF5678, 0, 0));
    tbl.push_back(mk(1, 2, 0, 11'h3FC, 32'hCAFEF00D, 32'h0, 0, 0));
    tbl.push_back(mk(1, 2, 0, 11'h400, 32'hFFFFFFFF, 32'h0, 0, 1));
    tbl.push_back(mk(0, 2, 0, 11'h3FC, 32'h0, 32'hCAFEF00D, 0, 0));
    tbl.push_back(mk(0, 0, 1, 11'h3FC, 32'h0, 32'hFFFFFFCA, 0, 0));
    tbl.push_back(mk(0, 0, 1, 11'h013, 32'h0, 32'h00000044, 0, 0));
    tbl.push_back(mk(0, 2, 0, 11'h7FC, 32'h0, 32'h0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 11'h401, 32'h0, 32'h0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 11'h7FF, 32'h0, 32'h0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 11'h011, 32'h123456AB, 32'h0, 0, 0));
    tbl.push_back(mk(0, 2, 0, 11'h010, 32'h0, 32'h11AB3344, 0, 0));
    tbl.push_back(mk(0, 1, 1, 11'h012, 32'h0, 32'h00003344, 0, 0));

    repeat (3) @(posedge clk);
    #1;
    chk_zero(0, "reset0");
    chk_zero(1, "reset1");
    @(negedge clk);
    rst_s[0] = 1'b1;
    rst_s[1] = 1'b1;

    for (int i = 0; i < tbl.size(); i++) issue(0, tbl[i]);

    // Request held high through busy; address changes after accept.
    @(negedge clk);
    drive(0, mk(0, 2, 0, 11'h010, 32'h0, 32'h0, 0, 0));
    @(posedge clk);
    @(negedge clk);
    addr_s[0] = 11'h020;
    n = 1;
    while (!ack_w[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("held_lat1", n, WS0 + 1);
    chk("held_latched_addr", rdata_w[0], 32'h11AB3344);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ack_w[0] && n < 20);
    chk("held_ack_gap", n, WS0 + 2);
    chk("held_second_rdata", rdata_w[0], 32'h80FF5678);
    req_s[0] = 1'b0;
    n = 0;
    repeat (6) begin
      @(negedge clk);
      if (ack_w[0]) n++;
    end
    chk("held_no_extra_ack", n, 0);

    // Reset aborts a write in WAIT, then another in RESP.
    issue(1, mk(1, 2, 0, 11'h040, 32'h01020304, 32'h0, 0, 0));
    issue(1, mk(0, 2, 0, 11'h040, 32'h0, 32'h01020304, 0, 0));

    @(negedge clk);
    drive(1, mk(1, 2, 0, 11'h040, 32'hDEADBEEF, 32'h0, 0, 0));
    @(posedge clk);
    @(negedge clk);
    req_s[1] = 1'b0;
    @(negedge clk);
    chk("abort_wait_busy", 32'(busy_w[1]), 32'd1);
    rst_s[1] = 1'b0;
    #1;
    chk_zero(1, "abort_wait");
    @(posedge clk);
    #2;
    rst_s[1] = 1'b1;
    issue(1, mk(0, 2, 0, 11'h040, 32'h0, 32'h01020304, 0, 0));

    @(negedge clk);
    drive(1, mk(1, 2, 0, 11'h040, 32'hDEADBEEF, 32'h0, 0, 0));
    @(posedge clk);
    @(negedge clk);
    req_s[1] = 1'b0;
    n = 1;
    while (!ack_w[1] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("abort_resp_ack", 32'(ack_w[1]), 32'd1);
    rst_s[1] = 1'b0;
    #1;
    chk_zero(1, "abort_resp");
    @(posedge clk);
    #2;
    rst_s[1] = 1'b1;
    issue(1, mk(0, 2, 0, 11'h040, 32'h0, 32'h01020304, 0, 0));
    issue(1, mk(0, 0, 1, 11'h041, 32'h0, 32'h00000002, 0, 0));

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
